seq_mult_param: RTL

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

---
 rtl/seq_mult_param_if.sv | 31 +++
 rtl/seq_mult_param.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seq_mult_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_param_if
//  Brief    : Request/response bundle for the sequential multiplier.
//             Signal names keep the multiplier's own port directions
//             (_i into the multiplier, _o out of it).
//             master = requester side, slave = multiplier side.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                 start_i;
    logic                 abort_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 busy_o;
    logic                 valid_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
        output start_i, abort_i, a_i, b_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, abort_i, a_i, b_i,
        output busy_o, valid_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_param
//  Brief    : Shift-and-add multiplier, one multiplier bit per cycle.
//             IDLE -> CALC (WIDTH cycles) -> DONE, with abort and
//             back-to-back restart from DONE.
//             Optional macro SEQ_MULT_SIGNED_EN selects two's complement
//             operands (sign-extended partial products, subtract on the
//             multiplier sign bit); default build is unsigned.
//  Revision : 1.0  initial release
// ============================================================================
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    seq_mult_param_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [PW-1:0]      acc_q;
    logic               busy_q;
    logic               valid_q;

    logic [PW-1:0]      b_ext_d;
    logic [PW-1:0]      pp_d;
    logic [PW-1:0]      acc_d;
    logic               last_d;

    // Multiplicand widened to product width before shifting
`ifdef SEQ_MULT_SIGNED_EN
    assign b_ext_d = {{WIDTH{b_q[WIDTH-1]}}, b_q};
`else
    assign b_ext_d = {{WIDTH{1'b0}}, b_q};
`endif

    // Next accumulator value for the current iteration
    always_comb begin
        last_d = (cnt_q == CNT_W'(WIDTH - 1));
        pp_d   = b_ext_d << cnt_q;
        acc_d  = acc_q;
        if (a_q[cnt_q]) begin
`ifdef SEQ_MULT_SIGNED_EN
            // Multiplier sign bit carries weight -2^(WIDTH-1)
            if (last_d) begin
                acc_d = acc_q - pp_d;
            end else begin
                acc_d = acc_q + pp_d;
            end
`else
            acc_d = acc_q + pp_d;
`endif
        end
    end

    // Control FSM, datapath registers and registered status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (bus.start_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        if (last_d) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (bus.start_i) begin
                        // Restart directly without passing through IDLE
                        a_q     <= bus.a_i;
                        b_q     <= bus.b_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = acc_q;

endmodule
`default_nettype wire
